// File: rtl/time_uart_tx_pkg.sv
// Shared state encoding, constants and digit helper for the HH:MM:SS UART transmitter.
package time_uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      GAP   = 3'd4
   } tx_state_t;

   localparam int         DEFAULT_BIT_CYCLES = 5210;
   localparam int         NUM_BYTES          = 6;
   localparam logic [7:0] ASCII_ZERO         = 8'h30;

   // Saturates a 7-bit binary value at 99 and returns {tens, units}.
   function automatic logic [7:0] to_digits(input logic [6:0] value);
      logic [6:0] clamped;
      clamped = (value > 7'd99) ? 7'd99 : value;
      return {4'(clamped / 7'd10), 4'(clamped % 7'd10)};
   endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Per-byte serializer: bit timer, bit index and the registered serial line,
// slaved to the sequencer state so framing follows START/DATA/STOP exactly.
module uart_byte_tx
   import time_uart_tx_pkg::*;
#(
   parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  tx_state_t  state,
   input  tx_state_t  next_state,
   input  logic [7:0] data,
   output logic       bit_end,
   output logic       last_bit,
   output logic       txd
);

   localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_next;
   logic          txd_d;

   assign bit_end  = (timer == TW'(BIT_CYCLES - 1));
   assign last_bit = (bit_idx == 3'd7);

   // The line is registered from the next state so it changes cleanly on the
   // same edge as the state it represents.
   // NOTE: every variable assigned here gets a default first, so no latch is inferred.
   always_comb begin
      bit_next = bit_idx;
      txd_d    = 1'b1;
      if (state == DATA && bit_end) begin
         bit_next = bit_idx + 3'd1;
      end
      case (next_state)
         START:   txd_d = 1'b0;
         DATA:    txd_d = data[bit_next];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer   <= '0;
         bit_idx <= '0;
         txd     <= 1'b1;
      end else begin
         txd <= txd_d;
         if (state == IDLE || bit_end) begin
            timer <= '0;
         end else begin
            timer <= timer + 1'b1;
         end
         if (state == IDLE) begin
            bit_idx <= '0;
         end else if (state == DATA && bit_end) begin
            bit_idx <= bit_next;
         end
      end
   end

endmodule

// File: rtl/time_uart_tx.sv
// Sends a captured HH:MM:SS time as six ASCII digits over a UART line,
// followed by an idle gap and a one-cycle done pulse.
module time_uart_tx
   import time_uart_tx_pkg::*;
#(
   parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
   parameter int GAP_BITS   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [6:0] hour,
   input  logic [6:0] minute,
   input  logic [6:0] second,
   output logic       uart,
   output logic       busy,
   output logic       done
);

   localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

   tx_state_t state;
   tx_state_t next_state;

   logic [2:0]                  byte_idx;
   logic [GW-1:0]               gap_idx;
   logic [NUM_BYTES-1:0][3:0]   digits;
   logic [7:0]                  hour_d, minute_d, second_d;
   logic [7:0]                  tx_byte;
   logic                        bit_end, last_bit, last_byte, last_gap, accept;
   logic                        busy_d, done_d;

   assign hour_d    = to_digits(hour);
   assign minute_d  = to_digits(minute);
   assign second_d  = to_digits(second);
   assign accept    = (state == IDLE) && start;
   assign last_byte = (byte_idx == 3'(NUM_BYTES - 1));
   assign last_gap  = (gap_idx == GW'(GAP_BITS - 1));
   assign tx_byte   = ASCII_ZERO + {4'h0, digits[byte_idx]};

   // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= busy_d;
         done  <= done_d;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (start) next_state = START;
         START: if (bit_end) next_state = DATA;
         DATA:  if (bit_end && last_bit) next_state = STOP;
         STOP: begin
            if (bit_end) begin
               if (!last_byte)        next_state = START;
               else if (GAP_BITS > 0) next_state = GAP;
               else                   next_state = IDLE;
            end
         end
         GAP:   if (bit_end && last_gap) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered from the next state, so done lands in the first idle cycle.
   always_comb begin
      busy_d = (next_state != IDLE);
      done_d = (state != IDLE) && (next_state == IDLE);
   end

   // NOTE: the captured digits are reset with the control state so no X can reach the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx <= '0;
         gap_idx  <= '0;
         digits   <= '0;
      end else begin
         if (next_state == IDLE) begin
            byte_idx <= '0;
            gap_idx  <= '0;
         end else begin
            if (state == STOP && bit_end && !last_byte) byte_idx <= byte_idx + 3'd1;
            if (state == GAP && bit_end)                gap_idx  <= gap_idx + 1'b1;
         end
         if (accept) begin
            digits <= {second_d[3:0], second_d[7:4], minute_d[3:0], minute_d[7:4],
                       hour_d[3:0], hour_d[7:4]};
         end
      end
   end

   uart_byte_tx #(.BIT_CYCLES(BIT_CYCLES)) u_byte_tx (
      .clk        (clk),
      .rst_n      (rst_n),
      .state      (state),
      .next_state (next_state),
      .data       (tx_byte),
      .bit_end    (bit_end),
      .last_bit   (last_bit),
      .txd        (uart)
   );

endmodule

// File: tb/tb_time_uart_tx.sv
// Self-checking bench for time_uart_tx: table vectors, random times against an
// ideal waveform model, and hand-written abort / overlap / back-to-back sequences.
`timescale 1ns/1ps
module tb_time_uart_tx;

   localparam int C  = 16;
   localparam int G  = 2;
   localparam int L  = (60 + G) * C;
   localparam int NB = 6;

   logic       clk = 1'b0;
   logic       rst_n, start;
   logic [6:0] hour, minute, second;
   logic       uart, busy, done;

   always #5 clk = ~clk;

   time_uart_tx #(.BIT_CYCLES(C), .GAP_BITS(G)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .hour(hour), .minute(minute), .second(second),
      .uart(uart), .busy(busy), .done(done)
   );

   typedef struct {
      int unsigned h;
      int unsigned m;
      int unsigned s;
      logic [47:0] exp;
      string       name;
   } vec_t;

   int   tests = 0;
   int   fails = 0;
   logic cap_uart[$];
   logic cap_busy[$];
   logic cap_done[$];

   task automatic check(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, actual, actual, expected, expected);
      end
   endtask

   // Reference: clamp at 99, split into decimal digits, add ASCII '0'.
   function automatic logic [7:0] ascii_digit(input int unsigned value, input bit tens);
      int unsigned v;
      v = (value > 99) ? 99 : value;
      return 8'(32'h30 + (tens ? v / 10 : v % 10));
   endfunction

   function automatic logic [47:0] model_msg(input int unsigned h, input int unsigned m,
                                              input int unsigned s);
      return {ascii_digit(h, 1'b1), ascii_digit(h, 1'b0), ascii_digit(m, 1'b1),
              ascii_digit(m, 1'b0), ascii_digit(s, 1'b1), ascii_digit(s, 1'b0)};
   endfunction

   // Ideal line level k cycles after the accepting edge: ten C-cycle slots per byte.
   function automatic logic wave_bit(input logic [47:0] msg, input int k);
      int         j, pos;
      logic [7:0] b;
      if (k >= 60 * C) return 1'b1;
      j   = k / (10 * C);
      pos = (k % (10 * C)) / C;
      b   = msg[47 - 8 * j -: 8];
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return b[pos - 1];
   endfunction

   task automatic capture(input int n);
      cap_uart.delete();
      cap_busy.delete();
      cap_done.delete();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cap_uart.push_back(uart);
         cap_busy.push_back(busy);
         cap_done.push_back(done);
      end
   endtask

   task automatic launch(input int unsigned h, input int unsigned m, input int unsigned s);
      @(negedge clk);
      rst_n  = 1'b1;
      hour   = 7'(h);
      minute = 7'(m);
      second = 7'(s);
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic compare_message(input string name, input logic [47:0] msg, input int offset);
      int         bad, busy_len, done_at, done_cnt;
      logic       want_bit;
      logic [7:0] got, want;
      bad      = 0;
      busy_len = L + 1;
      done_at  = -1;
      done_cnt = 0;
      for (int k = 0; k <= L; k++) begin
         want_bit = (k < L) ? wave_bit(msg, k) : 1'b1;
         if (cap_uart[offset + k] !== want_bit) bad++;
         if (cap_busy[offset + k] !== 1'b1 && busy_len == L + 1) busy_len = k;
         if (cap_done[offset + k] === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
      end
      check({name, " wave_bad_cycles"}, bad, 0);
      for (int j = 0; j < NB; j++) begin
         for (int i = 0; i < 8; i++) got[i] = cap_uart[offset + j * 10 * C + (i + 1) * C + C / 2];
         want = msg[47 - 8 * j -: 8];
         check($sformatf("%s byte%0d", name, j), int'(got), int'(want));
      end
      check({name, " busy_len"}, busy_len, L);
      check({name, " done_at"}, done_at, L);
      check({name, " done_cnt"}, done_cnt, 1);
   endtask

   task automatic check_idle(input string name, input int n);
      int lows, busys, dones;
      lows = 0; busys = 0; dones = 0;
      capture(n);
      for (int k = 0; k < n; k++) begin
         if (cap_uart[k] !== 1'b1) lows++;
         if (cap_busy[k] !== 1'b0) busys++;
         if (cap_done[k] !== 1'b0) dones++;
      end
      check({name, " uart_low_cycles"}, lows, 0);
      check({name, " busy_cycles"}, busys, 0);
      check({name, " done_cycles"}, dones, 0);
   endtask

   initial begin
      vec_t        vecs[5];
      int unsigned h, m, s;
      int          gap;

      vecs[0] = '{12, 34, 56, 48'h31_32_33_34_35_36, "t12_34_56"};
      vecs[1] = '{0, 0, 0, 48'h30_30_30_30_30_30, "t00_00_00"};
      vecs[2] = '{127, 100, 9, 48'h39_39_39_39_30_39, "t_clamp"};
      vecs[3] = '{23, 59, 59, 48'h32_33_35_39_35_39, "t23_59_59"};
      vecs[4] = '{99, 5, 10, 48'h39_39_30_35_31_30, "t99_05_10"};

      rst_n = 1'b1; start = 1'b0; hour = '0; minute = '0; second = '0;
      #2 rst_n = 1'b0;
      #1;
      check("reset uart", int'(uart), 1);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("in_reset start_ignored busy", int'(busy), 0);
      check("in_reset uart", int'(uart), 1);
      start = 1'b0;

      // The first launch releases reset and starts on the same edge.
      for (int v = 0; v < 5; v++) begin
         launch(vecs[v].h, vecs[v].m, vecs[v].s);
         capture(L + 1);
         compare_message(vecs[v].name, vecs[v].exp, 0);
      end

      for (int r = 0; r < 4; r++) begin
         h = $urandom_range(0, 127);
         m = $urandom_range(0, 127);
         s = $urandom_range(0, 127);
         launch(h, m, s);
         capture(L + 1);
         compare_message($sformatf("rand%0d_%0d_%0d_%0d", r, h, m, s), model_msg(h, m, s), 0);
      end

      // Start pulse and new inputs in the middle of a message are ignored.
      launch(12, 34, 56);
      fork
         capture(L + 1);
         begin
            repeat (25 * C) @(negedge clk);
            hour = 7'd7; minute = 7'd8; second = 7'd9; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      compare_message("overlap", model_msg(12, 34, 56), 0);
      check_idle("overlap_after", 4 * C);

      // Reset during the third byte aborts at once; no partial byte afterwards.
      launch(11, 22, 33);
      repeat (25 * C) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort uart", int'(uart), 1);
      check("abort busy", int'(busy), 0);
      check("abort done", int'(done), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_idle("abort_release", 12 * C);
      launch(21, 43, 5);
      capture(L + 1);
      compare_message("after_abort", model_msg(21, 43, 5), 0);

      // Start held high through done: next message starts on the done cycle's edge.
      @(negedge clk);
      hour = 7'd1; minute = 7'd2; second = 7'd3; start = 1'b1;
      fork
         capture(2 * L + 2);
         begin
            @(posedge clk);
            #1 hour = 7'd4; minute = 7'd5; second = 7'd6;
            repeat (L + 5) @(negedge clk);
            start = 1'b0;
         end
      join
      compare_message("b2b_first", model_msg(1, 2, 3), 0);
      compare_message("b2b_second", model_msg(4, 5, 6), L + 1);
      gap = 0;
      for (int k = 60 * C; k < 2 * L + 2; k++) begin
         if (cap_uart[k] !== 1'b1) break;
         gap++;
      end
      // GAP_BITS bit times of idle-high, plus the single done cycle where busy is low.
      check("b2b gap_cycles", gap, G * C + 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
